fp_mult_result_fifo: RTL and testbench
======================================

Name: fp_mult_result_fifo

Overview:
Downstream stage of fp_mult_top. Captures each product word z and its 8-bit status into a small FIFO, then presents them to the consumer with a valid/ready handshake. Because fp_mult_top has no stall input, the block also keeps IEEE-style sticky exception flags and a saturating drop counter for results lost while the FIFO is full.

Parameters:
DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2
DATA_W, 32, width of the result word (IEEE single precision)
STAT_W, 8, width of the status word
CNT_W, 16, width of the drop counter

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  a fp_mult_top result is present this cycle
in_z  input  DATA_W  result word from fp_mult_top z
in_status  input  STAT_W  status word from fp_mult_top status
in_ready  output  1  FIFO can accept; informational only, since the producer cannot stall
out_valid  output  1  head entry is valid
out_z  output  DATA_W  head result word
out_status  output  STAT_W  head status word
out_ready  input  1  consumer accepts the head entry
flags  output  STAT_W  sticky OR of the status of every accepted entry
flags_clr  input  1  synchronous clear of flags
count  output  $clog2(DEPTH)+1  current occupancy
overflow  output  1  sticky; set when any result has been dropped
drop_cnt  output  CNT_W  number of dropped results, saturating
ovf_clr  input  1  synchronous clear of overflow and drop_cnt

Behaviour:
- Status bit meanings: [0] zero, [1] inf, [2] nan, [3] tiny, [4] huge, [5] inexact, [7:6] reserved. The FIFO stores all bits unchanged and does not interpret them.
- Reset (asynchronous, takes effect on rst=1):
  - Pointers and count go to 0, so out_valid=0 and in_ready=1.
  - flags, overflow and drop_cnt go to 0.
  - Storage contents are not cleared.
  - out_z and out_status show storage[0] and are don't-care while out_valid=0.
  - Reset asserted mid-operation discards all entries. No handshake completes in that cycle.
- Storage is a register array indexed by wr_ptr and rd_ptr. Each pointer is log2(DEPTH) bits and wraps naturally.
- Full and empty: full = (count==DEPTH), empty = (count==0).
- Outputs:
  - in_ready = !full, driven from a register; there is no combinational path from out_ready.
  - out_valid = !empty.
  - out_z and out_status are a combinational read of storage[rd_ptr].
- Push: when in_valid && !full, write the entry at wr_ptr and increment wr_ptr.
- Pop: when out_valid && out_ready, increment rd_ptr.
- count update:
  - count +1 on push only.
  - count -1 on pop only.
  - count unchanged when push and pop happen in the same cycle (both allowed when not full and not empty).
- Drop: when in_valid && full, the incoming entry is discarded. This applies even if a pop happens in the same cycle.
  - overflow is set to 1.
  - drop_cnt increments and saturates at 2^CNT_W-1.
- flags: on push, flags |= in_status. A dropped result does not update flags.
  - flags_clr with a push in the same cycle: flags <= in_status.
  - flags_clr with no push: flags <= 0.
- ovf_clr with a drop in the same cycle: overflow <= 1 and drop_cnt <= 1.
- Latency: an entry pushed at edge N is visible on out_* (out_valid=1) after edge N, so it can be popped at edge N+1.
- The consumer may hold out_ready high continuously. The FIFO then sustains one entry per cycle.

Test Plan:
1. Reset, then push in_z=32'h3F800000 with status 8'h00 for one cycle, out_ready=0. Expect count=1, out_valid=1, out_z=32'h3F800000 after the edge; in_ready stays 1.
2. With out_ready=0, push 5 consecutive results (z=1..5) at DEPTH=4. Expect count=4, in_ready=0 after the 4th push. The 5th is dropped: overflow=1, drop_cnt=1. Then pop 4 and expect z=1,2,3,4 in order, after which out_valid=0.
3. Streaming: in_valid=1 and out_ready=1 for 10 cycles with z=i. Expect count to stay at 1 after the first cycle, the outputs in order, no drops, and pointers wrapping past DEPTH with correct data.
4. Flags: push status 8'h04 (nan), then 8'h20 (inexact). Expect flags=8'h24. Assert flags_clr together with a push of status 8'h02. Expect flags=8'h02.
5. Full FIFO with out_ready=1 and in_valid=1 in the same cycle: the pop completes and the push is dropped. Expect count=3, drop_cnt +1. Then assert ovf_clr without a drop and expect overflow=0, drop_cnt=0.
6. Assert asynchronous rst mid-stream with count=3, between clock edges. Expect out_valid=0, count=0, flags=0 and overflow=0 immediately, before the next edge. After release, the first push appears at the head.

Source files
------------

// File: rtl/fp_mult_result_fifo.sv
// Result FIFO behind fp_mult_top: buffers product/status pairs for a valid/ready
// consumer and records sticky exception flags plus a saturating count of dropped results.
module fp_mult_result_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int STAT_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_z,
  input  logic [STAT_W-1:0]        in_status,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_z,
  output logic [STAT_W-1:0]        out_status,
  input  logic                     out_ready,
  output logic [STAT_W-1:0]        flags,
  input  logic                     flags_clr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  input  logic                     ovf_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] DROP_ONE = CNT_W'(1);

  logic [DATA_W-1:0] z_mem_q  [DEPTH];
  logic [STAT_W-1:0] st_mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  count_q, count_d;
  logic              in_ready_q, in_ready_d;
  logic [STAT_W-1:0] flags_q, flags_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic full, empty, push, pop, drop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = in_valid && !full;
  // A full FIFO drops the incoming result even when a pop frees a slot this cycle.
  assign drop  = in_valid && full;
  assign pop   = !empty && out_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    flags_d    = flags_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    if (push && !pop)      count_d = count_q + OCC_ONE;
    else if (pop && !push) count_d = count_q - OCC_ONE;

    if (flags_clr)  flags_d = push ? in_status : '0;
    else if (push)  flags_d = flags_q | in_status;

    if (drop) begin
      overflow_d = 1'b1;
      if (ovf_clr)                drop_cnt_d = DROP_ONE;
      else if (drop_cnt_q != '1)  drop_cnt_d = drop_cnt_q + DROP_ONE;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end

    // Registered so in_ready never depends combinationally on out_ready.
    in_ready_d = (count_d != FULL_CNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
      flags_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      flags_q    <= flags_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      z_mem_q[wr_ptr_q]  <= in_z;
      st_mem_q[wr_ptr_q] <= in_status;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = !empty;
  assign out_z      = z_mem_q[rd_ptr_q];
  assign out_status = st_mem_q[rd_ptr_q];
  assign flags      = flags_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_fp_mult_result_fifo.sv
// Directed bench for fp_mult_result_fifo; a second small instance exercises drop counter saturation.
module tb_fp_mult_result_fifo;

  logic        clk, rst;
  logic        in_valid, out_ready, flags_clr, ovf_clr;
  logic [31:0] in_z;
  logic [7:0]  in_status;
  logic        in_ready, out_valid, overflow;
  logic [31:0] out_z;
  logic [7:0]  out_status, flags;
  logic [2:0]  count;
  logic [15:0] drop_cnt;

  logic        s_in_valid, s_out_ready, s_in_ready, s_out_valid, s_overflow;
  logic [31:0] s_out_z;
  logic [7:0]  s_out_status, s_flags;
  logic [1:0]  s_count, s_drop_cnt;

  int tests = 0;
  int fails = 0;

  fp_mult_result_fifo dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_z(in_z), .in_status(in_status),
    .in_ready(in_ready), .out_valid(out_valid), .out_z(out_z), .out_status(out_status),
    .out_ready(out_ready), .flags(flags), .flags_clr(flags_clr), .count(count),
    .overflow(overflow), .drop_cnt(drop_cnt), .ovf_clr(ovf_clr)
  );

  fp_mult_result_fifo #(.DEPTH(2), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_z(32'h0000_00AA), .in_status(8'h00),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_z(s_out_z), .out_status(s_out_status),
    .out_ready(s_out_ready), .flags(s_flags), .flags_clr(1'b0), .count(s_count),
    .overflow(s_overflow), .drop_cnt(s_drop_cnt), .ovf_clr(1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_z = '0; in_status = '0;
    out_ready = 0; flags_clr = 0; ovf_clr = 0;
    s_in_valid = 0; s_out_ready = 0;
    #12;
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_flags", flags, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    rst = 1'b0;

    // 1: single push
    in_valid = 1; in_z = 32'h3F80_0000; in_status = 8'h00;
    tick();
    in_valid = 0;
    check("t1_count", count, 1);
    check("t1_out_valid", out_valid, 1);
    check("t1_out_z", out_z, 32'h3F80_0000);
    check("t1_in_ready", in_ready, 1);
    out_ready = 1;
    tick();
    out_ready = 0;
    check("t1_pop_count", count, 0);

    // 2: fill, drop one, drain in order
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1; in_z = 32'(i);
      tick();
      if (i == 4) begin
        check("t2_full_count", count, 4);
        check("t2_full_in_ready", in_ready, 0);
        check("t2_no_ovf_yet", overflow, 0);
      end
    end
    in_valid = 0;
    check("t2_overflow", overflow, 1);
    check("t2_drop_cnt", drop_cnt, 1);
    check("t2_count_after_drop", count, 4);
    out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      check("t2_pop_z", out_z, 64'(i));
      tick();
    end
    out_ready = 0;
    check("t2_empty", out_valid, 0);
    check("t2_in_ready_back", in_ready, 1);

    // 3: streaming with wrap
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      in_z = 32'(100 + i);
      if (i > 0) check("t3_stream_z", out_z, 64'(100 + i - 1));
      tick();
      check("t3_stream_count", count, 1);
    end
    in_valid = 0;
    check("t3_last_z", out_z, 109);
    tick();
    out_ready = 0;
    check("t3_empty", out_valid, 0);
    check("t3_no_new_drops", drop_cnt, 1);

    // 4: sticky flags
    in_valid = 1; in_z = 32'h7FC0_0000; in_status = 8'h04;
    tick();
    in_z = 32'h3F80_0001; in_status = 8'h20;
    tick();
    check("t4_flags_or", flags, 8'h24);
    flags_clr = 1; in_status = 8'h02;
    tick();
    in_valid = 0;
    check("t4_clr_push", flags, 8'h02);
    check("t4_head_status", out_status, 8'h04);
    check("t4_count", count, 3);
    tick();
    flags_clr = 0;
    check("t4_clr_nopush", flags, 8'h00);

    // 5: drop on a full FIFO despite a simultaneous pop
    in_valid = 1; in_status = 8'h10; in_z = 32'h0000_0055;
    tick();
    check("t5_full", count, 4);
    check("t5_flags", flags, 8'h10);
    out_ready = 1; in_status = 8'h01;
    tick();
    in_valid = 0; out_ready = 0;
    check("t5_pop_drop_count", count, 3);
    check("t5_drop_cnt", drop_cnt, 2);
    check("t5_flags_unchanged", flags, 8'h10);
    ovf_clr = 1;
    tick();
    check("t5_ovf_clr", overflow, 0);
    check("t5_drop_clr", drop_cnt, 0);
    ovf_clr = 0; in_valid = 1; in_status = 8'h00;
    tick();
    ovf_clr = 1;
    tick();
    ovf_clr = 0; in_valid = 0;
    check("t5_clr_with_drop_ovf", overflow, 1);
    check("t5_clr_with_drop_cnt", drop_cnt, 1);
    out_ready = 1;
    tick();
    out_ready = 0;
    check("t6_pre_count", count, 3);

    // 6: asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_valid", out_valid, 0);
    check("t6_async_count", count, 0);
    check("t6_async_flags", flags, 0);
    check("t6_async_ovf", overflow, 0);
    check("t6_async_drop", drop_cnt, 0);
    check("t6_async_in_ready", in_ready, 1);
    #1;
    rst = 1'b0;
    in_valid = 1; in_z = 32'hCAFE_F00D; in_status = 8'h08;
    tick();
    in_valid = 0;
    check("t6_first_valid", out_valid, 1);
    check("t6_first_z", out_z, 32'hCAFE_F00D);
    check("t6_first_count", count, 1);

    // saturation on the 2-bit drop counter
    s_in_valid = 1;
    for (int i = 0; i < 6; i++) tick();
    s_in_valid = 0;
    check("sat_count", s_count, 2);
    check("sat_overflow", s_overflow, 1);
    check("sat_drop_cnt", s_drop_cnt, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
